// File: rtl/upscaler_line_scheduler_pkg.sv
// Shared definitions for the upscaler line scheduler.
//   - Ring, width and step parameters.
//   - Divider FSM state encoding.
//   - Unity step constant (1.0 in the h_delta/v_delta fixed-point format).
//   - Saturation limit for h_delta, widened to the quotient width.
package upscaler_line_scheduler_pkg;

  localparam int C_LINE_BUFFER_COUNT = 8;
  localparam int C_INDEX_WIDTH       = 3;
  localparam int C_WIDTH_BITS        = 11;
  localparam int C_DELTA_WIDTH       = 8;

  // The dividend is src_width << C_DELTA_WIDTH.
  // One quotient bit is produced per cycle.
  localparam int C_DIV_STEPS = C_WIDTH_BITS + C_DELTA_WIDTH;

  localparam logic [C_DELTA_WIDTH:0] C_UNITY_STEP =
    (C_DELTA_WIDTH+1)'(1 << C_DELTA_WIDTH);

  // Largest representable h_delta (just under 2.0), widened to the quotient width.
  localparam logic [C_DIV_STEPS-1:0] C_H_DELTA_MAX =
    C_DIV_STEPS'((1 << (C_DELTA_WIDTH+1)) - 1);

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_DONE   = 2'd2
  } div_state_t;

endpackage

// File: rtl/upscaler_line_scheduler_seq_divider.sv
// seq_divider: restoring unsigned divider that resolves one quotient bit per cycle.
// Ports:
//   pixel_clk, rst  clock and asynchronous active-high reset
//   start           accepted only in IDLE; latches dividend and divisor
//   dividend        numerator, DIVIDEND_W bits
//   divisor         denominator, DIVISOR_W bits; the caller keeps it non-zero
//   busy            high for exactly DIVIDEND_W cycles while bits are resolved
//   done            high for the one cycle in which quotient is final
//   quotient        result register; holds its value until the next start
module seq_divider
  import upscaler_line_scheduler_pkg::*;
#(
  parameter int DIVIDEND_W = 19,
  parameter int DIVISOR_W  = 11
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int                CNT_W    = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DIVIDEND_W - 1);

  div_state_t             state, state_next;
  logic [DIVIDEND_W-1:0]  dvd_q;
  logic [DIVISOR_W-1:0]   dsr_q;
  logic [DIVISOR_W-1:0]   rem_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DIVISOR_W:0]     trial;
  logic [DIVISOR_W:0]     diff;
  logic                   fits;

  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // register samples pre-edge values, whatever the order of the statements.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default first.
  // Without it, a path that leaves one unassigned infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE:   if (start) state_next = DIV_DIVIDE;
      DIV_DIVIDE: if (cnt_q == LAST_BIT) state_next = DIV_DONE;
      DIV_DONE:   state_next = DIV_IDLE;
      default:    state_next = DIV_IDLE;
    endcase
  end

  // Restoring step: bring down the next dividend bit.
  // Subtract the divisor only when the partial remainder is large enough.
  always_comb begin
    trial = {rem_q, dvd_q[DIVIDEND_W-1]};
    diff  = trial - {1'b0, dsr_q};
    fits  = (trial >= {1'b0, dsr_q});
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      quotient <= '0;
    end else if (state == DIV_IDLE && start) begin
      dvd_q    <= dividend;
      dsr_q    <= divisor;
      rem_q    <= '0;
      cnt_q    <= '0;
      quotient <= '0;
    end else if (state == DIV_DIVIDE) begin
      dvd_q    <= dvd_q << 1;
      rem_q    <= fits ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
      quotient <= {quotient[DIVIDEND_W-2:0], fits};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign busy = (state == DIV_DIVIDE);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/upscaler_line_scheduler.sv
// upscaler_line_scheduler: sequences the line-buffer ring in the output pixel domain.
// It also derives the horizontal step.
// Ports:
//   pixel_clk, rst                  sole clock; asynchronous active-high reset
//   src_line_done, src_line_width   source finished a line; that line's active width
//   src_vsync                       source frame start; flushes the ring
//   dst_line_start, dst_line_width  output line start; output active width
//   dst_vsync                       output frame start; clears the vertical phase
//   v_delta                         vertical step per output line (clamped to 1.0)
//   write_index, read_index         ring buffers used by the source and the output
//   fill_level                      completed lines not yet retired
//   h_delta, h_delta_valid          horizontal step; set once the first division is done
//   busy                            divider running
//   overflow, underflow             one-cycle error pulses
module upscaler_line_scheduler
  import upscaler_line_scheduler_pkg::*;
(
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic                       src_line_done,
  input  logic [C_WIDTH_BITS-1:0]    src_line_width,
  input  logic                       src_vsync,
  input  logic                       dst_line_start,
  input  logic [C_WIDTH_BITS-1:0]    dst_line_width,
  input  logic                       dst_vsync,
  input  logic [C_DELTA_WIDTH:0]     v_delta,
  output logic [C_INDEX_WIDTH-1:0]   write_index,
  output logic [C_INDEX_WIDTH-1:0]   read_index,
  output logic [C_INDEX_WIDTH:0]     fill_level,
  output logic [C_DELTA_WIDTH:0]     h_delta,
  output logic                       h_delta_valid,
  output logic                       busy,
  output logic                       overflow,
  output logic                       underflow
);

  // One slot is always kept free, so the ring counts as full at COUNT-1 lines.
  localparam logic [C_INDEX_WIDTH:0] FILL_FULL = (C_INDEX_WIDTH+1)'(C_LINE_BUFFER_COUNT - 1);

  logic [C_WIDTH_BITS-1:0]  src_width_q;
  logic [C_DELTA_WIDTH-1:0] v_frac_q;
  logic [C_DELTA_WIDTH:0]   v_step;
  logic [C_DELTA_WIDTH:0]   v_sum;
  logic                     retire;
  logic                     div_start;
  logic                     div_done;
  logic [C_DIV_STEPS-1:0]   div_quotient;

  // Vertical phase accumulator.
  // A carry out of the fractional bits retires one source line.
  always_comb begin
    v_step = (v_delta > C_UNITY_STEP) ? C_UNITY_STEP : v_delta;
    v_sum  = {1'b0, v_frac_q} + v_step;
    retire = dst_line_start && !dst_vsync && v_sum[C_DELTA_WIDTH];
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst)                 v_frac_q <= '0;
    else if (dst_vsync)      v_frac_q <= '0;
    else if (dst_line_start) v_frac_q <= v_sum[C_DELTA_WIDTH-1:0];
  end

  // Ring bookkeeping.
  // Both the write and the retire decisions use the fill level from before this cycle.
  // Index arithmetic wraps naturally because the ring depth is a power of two.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      write_index <= '0;
      read_index  <= '0;
      fill_level  <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (src_vsync) begin
        write_index <= '0;
        read_index  <= '0;
        fill_level  <= '0;
      end else if (src_line_done && retire) begin
        write_index <= write_index + 1'b1;
        read_index  <= read_index + 1'b1;
      end else if (src_line_done) begin
        if (fill_level < FILL_FULL) begin
          write_index <= write_index + 1'b1;
          fill_level  <= fill_level + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (retire) begin
        if (fill_level != '0) begin
          read_index <= read_index + 1'b1;
          fill_level <= fill_level - 1'b1;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst)                src_width_q <= '0;
    else if (src_line_done) src_width_q <= src_line_width;
  end

  // The divider ignores start while it is busy.
  // A zero width on either side would give a meaningless step, so no division starts.
  assign div_start = dst_line_start && (src_width_q != '0) && (dst_line_width != '0);

  seq_divider #(
    .DIVIDEND_W (C_DIV_STEPS),
    .DIVISOR_W  (C_WIDTH_BITS)
  ) u_divider (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  ({src_width_q, {C_DELTA_WIDTH{1'b0}}}),
    .divisor   (dst_line_width),
    .busy      (busy),
    .done      (div_done),
    .quotient  (div_quotient)
  );

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_delta       <= C_UNITY_STEP;
      h_delta_valid <= 1'b0;
    end else if (div_done) begin
      h_delta       <= (div_quotient > C_H_DELTA_MAX) ? C_H_DELTA_MAX[C_DELTA_WIDTH:0]
                                                      : div_quotient[C_DELTA_WIDTH:0];
      h_delta_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upscaler_line_scheduler.sv
// Self-checking bench for upscaler_line_scheduler.
// Ring expectations are queued as each line event is driven.
// They are popped and compared one clock later.
// Expected h_delta values are queued when a division is launched.
// They are popped when the result is due.
module tb_upscaler_line_scheduler;

  logic        pixel_clk;
  logic        rst;
  logic        src_line_done;
  logic [10:0] src_line_width;
  logic        src_vsync;
  logic        dst_line_start;
  logic [10:0] dst_line_width;
  logic        dst_vsync;
  logic [8:0]  v_delta;
  logic [2:0]  write_index;
  logic [2:0]  read_index;
  logic [3:0]  fill_level;
  logic [8:0]  h_delta;
  logic        h_delta_valid;
  logic        busy;
  logic        overflow;
  logic        underflow;

  upscaler_line_scheduler dut (
    .pixel_clk      (pixel_clk),
    .rst            (rst),
    .src_line_done  (src_line_done),
    .src_line_width (src_line_width),
    .src_vsync      (src_vsync),
    .dst_line_start (dst_line_start),
    .dst_line_width (dst_line_width),
    .dst_vsync      (dst_vsync),
    .v_delta        (v_delta),
    .write_index    (write_index),
    .read_index     (read_index),
    .fill_level     (fill_level),
    .h_delta        (h_delta),
    .h_delta_valid  (h_delta_valid),
    .busy           (busy),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [2:0] wi;
    logic [2:0] ri;
    logic [3:0] fill;
    logic       ovf;
    logic       unf;
  } ring_exp_t;

  ring_exp_t  sb_q[$];
  logic [8:0] hd_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state of the ring, the vertical phase and the current h_delta.
  int m_wr, m_rd, m_fill, m_vfrac, m_hdelta;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_fill = 0; m_vfrac = 0; m_hdelta = 256;
  endtask

  // Drive one cycle of line and frame events.
  // The expected ring state is queued first, then compared after the clock edge.
  task automatic line_event(input logic sd, input logic [10:0] sw, input logic dls,
                            input logic [10:0] dw, input logic sv, input logic dv);
    ring_exp_t e;
    ring_exp_t got_e;
    int        s;
    int        vstep;
    logic      carry;
    vstep = (int'(v_delta) > 256) ? 256 : int'(v_delta);
    carry = 1'b0;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (dv) m_vfrac = 0;
    else if (dls) begin
      s       = m_vfrac + vstep;
      carry   = (s >= 256);
      m_vfrac = s % 256;
    end
    if (sv) begin
      m_wr = 0; m_rd = 0; m_fill = 0;
    end else if (sd && carry) begin
      m_wr = (m_wr + 1) % 8;
      m_rd = (m_rd + 1) % 8;
    end else if (sd) begin
      if (m_fill < 7) begin m_wr = (m_wr + 1) % 8; m_fill++; end
      else e.ovf = 1'b1;
    end else if (carry) begin
      if (m_fill > 0) begin m_rd = (m_rd + 1) % 8; m_fill--; end
      else e.unf = 1'b1;
    end
    e.wi   = 3'(m_wr);
    e.ri   = 3'(m_rd);
    e.fill = 4'(m_fill);
    sb_q.push_back(e);

    src_line_done  = sd;
    src_line_width = sw;
    dst_line_start = dls;
    dst_line_width = dw;
    src_vsync      = sv;
    dst_vsync      = dv;
    step();
    src_line_done  = 1'b0;
    dst_line_start = 1'b0;
    src_vsync      = 1'b0;
    dst_vsync      = 1'b0;

    got_e = sb_q.pop_front();
    check("write_index", write_index, got_e.wi);
    check("read_index",  read_index,  got_e.ri);
    check("fill_level",  fill_level,  got_e.fill);
    check("overflow",    overflow,    got_e.ovf);
    check("underflow",   underflow,   got_e.unf);
  endtask

  // Launch a division and then watch for a fixed window.
  // busy must last 19 cycles. h_delta must still be old 20 edges after the pulse was driven.
  // The new value must appear at the 21st edge.
  task automatic run_divide(input int src_w, input logic [10:0] dw);
    int exp_q;
    int busy_cycles;
    exp_q = (src_w * 256) / int'(dw);
    if (exp_q > 511) exp_q = 511;
    hd_q.push_back(9'(exp_q));
    line_event(1'b0, 11'd0, 1'b1, dw, 1'b0, 1'b0);
    busy_cycles = 0;
    for (int k = 1; k <= 24; k++) begin
      if (busy) busy_cycles++;
      if (k == 20) check("h_delta_before", h_delta, m_hdelta);
      if (k == 21) begin
        check("h_delta_after", h_delta, hd_q.pop_front());
        check("h_delta_valid", h_delta_valid, 1);
      end
      step();
    end
    check("busy_cycles", busy_cycles, 19);
    m_hdelta = exp_q;
  endtask

  initial begin
    rst            = 1'b1;
    src_line_done  = 1'b0;
    src_line_width = '0;
    src_vsync      = 1'b0;
    dst_line_start = 1'b0;
    dst_line_width = '0;
    dst_vsync      = 1'b0;
    v_delta        = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state.
    check("rst_h_delta", h_delta, 256);
    check("rst_valid",   h_delta_valid, 0);
    check("rst_busy",    busy, 0);
    check("rst_fill",    fill_level, 0);

    // Reset in the middle of a division.
    line_event(1'b1, 11'd288, 1'b0, 11'd0, 1'b0, 1'b0);
    line_event(1'b0, 11'd0, 1'b1, 11'd640, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("busy_mid_divide", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_busy",    busy, 0);
    check("async_h_delta", h_delta, 256);
    check("async_valid",   h_delta_valid, 0);
    check("async_wr_idx",  write_index, 0);
    check("async_rd_idx",  read_index, 0);
    check("async_fill",    fill_level, 0);
    model_reset();
    step();
    rst = 1'b0;
    step();

    // Fill the ring, then overflow it.
    for (int i = 0; i < 7; i++) line_event(1'b1, 11'd100, 1'b0, 11'd0, 1'b0, 1'b0);
    check("full_write_index", write_index, 7);
    check("full_fill", fill_level, 7);
    line_event(1'b1, 11'd100, 1'b0, 11'd0, 1'b0, 1'b0);
    step();
    check("overflow_one_cycle", overflow, 0);

    // Half-rate vertical stepping, running into underflow.
    line_event(1'b0, 11'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    v_delta = 9'd128;
    line_event(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1);
    line_event(1'b1, 11'd100, 1'b0, 11'd0, 1'b0, 1'b0);
    line_event(1'b1, 11'd100, 1'b0, 11'd0, 1'b0, 1'b0);
    begin
      logic [2:0] exp_ri [4];
      logic [3:0] exp_f  [4];
      exp_ri = '{3'd0, 3'd1, 3'd1, 3'd2};
      exp_f  = '{4'd2, 4'd1, 4'd1, 4'd0};
      for (int i = 0; i < 4; i++) begin
        line_event(1'b0, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0);
        check("half_rate_read_index", read_index, exp_ri[i]);
        check("half_rate_fill", fill_level, exp_f[i]);
      end
    end
    line_event(1'b0, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0);
    line_event(1'b0, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0);
    check("underflow_read_index", read_index, 2);

    // Horizontal step: normal quotient, then a saturating one.
    v_delta = 9'd0;
    line_event(1'b1, 11'd288, 1'b0, 11'd0, 1'b0, 1'b0);
    run_divide(288, 11'd640);
    line_event(1'b1, 11'd640, 1'b0, 11'd0, 1'b0, 1'b0);
    run_divide(640, 11'd288);
    check("saturated_h_delta", h_delta, 511);

    // A zero output width must not start a division.
    line_event(1'b0, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0);
    check("zero_width_no_busy", busy, 0);
    for (int i = 0; i < 25; i++) step();
    check("zero_width_h_held", h_delta, 511);

    // Same-cycle write and retire at an empty ring and at a full ring, then a flush.
    line_event(1'b0, 11'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    v_delta = 9'd256;
    line_event(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1);
    line_event(1'b1, 11'd50, 1'b1, 11'd0, 1'b0, 1'b0);
    check("both_at_empty_fill", fill_level, 0);
    for (int i = 0; i < 7; i++) line_event(1'b1, 11'd50, 1'b0, 11'd0, 1'b0, 1'b0);
    line_event(1'b1, 11'd50, 1'b1, 11'd0, 1'b0, 1'b0);
    check("both_at_full_fill", fill_level, 7);
    check("both_at_full_no_ovf", overflow, 0);
    line_event(1'b0, 11'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    check("flush_wr_idx", write_index, 0);
    check("flush_rd_idx", read_index, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
